// File: rtl/controller_nios2e_oci_pkg.sv
// Shared OCI trace definitions: atom/frame geometry, FSM states, frame record.
package controller_nios2e_oci_pkg;

    localparam int ATOM_W = 2;
    localparam int ATOMS  = 15;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 16;
    localparam int BUF_W  = ATOM_W * ATOMS;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Count plus right-aligned packed atoms, as carried by the hold register.
    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [BUF_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/controller_nios2e_oci_dct_packer_if.sv
// Frame output stream: valid/ready with packed buffer and atom count.
interface controller_nios2e_oci_dct_packer_if;

    logic                                      dct_valid;
    logic                                      dct_ready;
    logic [controller_nios2e_oci_pkg::BUF_W-1:0] dct_buffer;
    logic [controller_nios2e_oci_pkg::CNT_W-1:0] dct_count;

    modport master (output dct_valid, output dct_buffer, output dct_count, input dct_ready);
    modport slave  (input dct_valid, input dct_buffer, input dct_count, output dct_ready);

endinterface

// File: rtl/controller_nios2e_oci_dct_hold.sv
// One-entry valid/ready holding register; data is stable while valid is high.
module controller_nios2e_oci_dct_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         can_load,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Loading is allowed when empty or when the current entry leaves this cycle.
    assign can_load = !valid_q || ready;
    assign valid    = valid_q;
    assign data     = data_q;

    // Next-state: a load wins over the drain, otherwise drop the entry on transfer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Register the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/controller_nios2e_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom frames with flush, drop accounting and end-of-test drain.
module controller_nios2e_oci_dct_packer
    import controller_nios2e_oci_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trace_en,
    input  logic                 atom_valid,
    input  logic [ATOM_W-1:0]    atom,
    input  logic                 flush,
    input  logic                 end_req,
    controller_nios2e_oci_dct_packer_if.master dct,
    output logic                 test_ending,
    output logic                 test_has_ended,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_count
);

    logic [BUF_W-1:0]  acc_buf_q, acc_buf_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              pend_q, pend_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    state_t            state_q;
    logic              test_ending_q, test_has_ended_q;

    logic   acc_full, close, take, atom_ok, drop, accept, flush_req, hold_can_load;
    frame_t hold_frame;

    // Accumulator, pending-close flag and drop accounting.
    always_comb begin
        acc_full  = (acc_cnt_q == CNT_W'(ATOMS));
        close     = acc_full || (pend_q && acc_cnt_q != '0);
        take      = close && hold_can_load;
        // In DRAIN only atoms ahead of the drain flush count; later ones would never be flushed.
        atom_ok   = atom_valid && trace_en &&
                    ((state_q == RUN) || (state_q == DRAIN && pend_q && !take));
        drop      = atom_ok && acc_full && !take;
        accept    = atom_ok && !drop;
        flush_req = flush || (end_req && state_q == RUN);

        acc_buf_d  = acc_buf_q;
        acc_cnt_d  = acc_cnt_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (take) begin
            acc_buf_d = accept ? BUF_W'(atom) : '0;
            acc_cnt_d = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            acc_buf_d = {acc_buf_q[BUF_W-ATOM_W-1:0], atom};
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        // A flush only sticks if something will be left in the accumulator to close.
        pend_d = take ? 1'b0 : pend_q;
        if (flush_req && acc_cnt_d != '0)
            pend_d = 1'b1;

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1)
                drop_d = drop_q + DROP_W'(1);
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_buf_q  <= '0;
            acc_cnt_q  <= '0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            acc_buf_q  <= acc_buf_d;
            acc_cnt_q  <= acc_cnt_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // End-of-test FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= RUN;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (end_req) begin
                    state_q       <= DRAIN;
                    test_ending_q <= 1'b1;
                end
                DRAIN: if (acc_cnt_q == '0 && !pend_q && !dct.dct_valid) begin
                    state_q          <= DONE;
                    test_ending_q    <= 1'b0;
                    test_has_ended_q <= 1'b1;
                end
                default: state_q <= DONE;
            endcase
        end
    end

    controller_nios2e_oci_dct_hold #(.W($bits(frame_t))) u_hold (
        .clk       (clk),
        .rst       (reset),
        .load      (take),
        .load_data ({acc_cnt_q, acc_buf_q}),
        .can_load  (hold_can_load),
        .valid     (dct.dct_valid),
        .ready     (dct.dct_ready),
        .data      (hold_frame)
    );

    assign dct.dct_buffer = hold_frame.data;
    assign dct.dct_count  = hold_frame.cnt;
    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;
    assign overflow       = overflow_q;
    assign drop_count     = drop_q;

endmodule
